// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: frame defaults and receiver FSM encoding.
package serial_pkg;

  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int DATA_BITS_DEF    = 8;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_IDLE = 3'd4;

endpackage

// File: rtl/serial_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input, with a selectable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // two-stage capture of the asynchronous input
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// UART-style 8N1 receiver: synchronizes rx, checks mid-start, samples mid-bit, and
// presents each framed word with a one-cycle valid (or frame_err on a low stop bit).
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_BITS    = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);

  logic                 rx_s;
  logic [2:0]           state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [BW-1:0]        bitidx, bitidx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt, ferr_nxt, busy_nxt;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitidx    <= '0;
      shreg     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bitidx    <= bitidx_nxt;
      shreg     <= shreg_nxt;
      data_out  <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= ferr_nxt;
      busy      <= busy_nxt;
    end
  end

  // next-state: bit timing counters and data assembly
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    bitidx_nxt = bitidx;
    shreg_nxt  = shreg;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end else begin
          state_nxt = IDLE;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt    = '0;
          bitidx_nxt = '0;
          state_nxt  = rx_s ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt    = '0;
          shreg_nxt  = {rx_s, shreg[DATA_BITS-1:1]};
          bitidx_nxt = bitidx + BIT_ONE;
          state_nxt  = (bitidx == BIT_LAST) ? STOP : DATA;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          state_nxt = rx_s ? IDLE : WAIT_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      WAIT_IDLE: begin
        // a held-low line (break) must not look like a new start bit
        if (rx_s) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = WAIT_IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // output decode at the stop-bit sample
  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    data_nxt  = data_out;
    busy_nxt  = (state_nxt != IDLE);
    if ((state == STOP) && (cnt == CNT_FULL)) begin
      if (rx_s) begin
        valid_nxt = 1'b1;
        data_nxt  = shreg;
      end else begin
        ferr_nxt = 1'b1;
      end
    end else begin
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: directed test-plan frames plus random traffic, all
// compared cycle by cycle against a frame-level reference model of the recorded line.
module tb_serial_rx;
  import serial_pkg::*;

  localparam int CPB  = CLKS_PER_BIT_DEF;
  localparam int DB   = DATA_BITS_DEF;
  localparam int H    = CPB / 2;
  localparam int LAT  = 2 + H + (DB + 1) * CPB;
  localparam int NMAX = 20000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rx = 1'b1;
  logic [DB-1:0] data_out;
  logic          valid, frame_err, busy;

  serial_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // recorded line/reset per edge and DUT outputs just after each edge
  bit            line_rec [NMAX];
  bit            rst_rec  [NMAX];
  logic          v_rec    [NMAX];
  logic          f_rec    [NMAX];
  logic          b_rec    [NMAX];
  logic [DB-1:0] d_rec    [NMAX];
  bit            exp_v    [NMAX];
  bit            exp_f    [NMAX];
  bit            exp_b    [NMAX];
  logic [DB-1:0] exp_d    [NMAX];

  int n = 0;
  int n_checks = 0;
  int n_pass = 0;
  int cur_cyc = -1;

  always @(posedge clk) begin
    if (n < NMAX) begin
      line_rec[n] <= rx;
      rst_rec[n]  <= reset;
    end
  end

  always @(negedge clk) begin
    if (n < NMAX) begin
      v_rec[n] <= valid;
      f_rec[n] <= frame_err;
      b_rec[n] <= busy;
      d_rec[n] <= data_out;
    end
    n <= n + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", tag, got, exp, cur_cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int cycles);
    rx = v;
    repeat (cycles) tick();
  endtask

  // one frame; rst_bit >= 0 pulses reset for one edge as that data bit begins
  task automatic send_frame(input logic [DB-1:0] w, input logic stop_v, input int rst_bit,
                            output int fall);
    fall = n + 1;
    drive(1'b0, CPB);
    for (int i = 0; i < DB; i++) begin
      if (i == rst_bit) reset = 1'b1;
      rx = w[i];
      tick();
      reset = 1'b0;
      repeat (CPB - 1) tick();
    end
    drive(stop_v, CPB);
  endtask

  task automatic wait_not_busy(input int limit);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < limit) begin
      tick();
      k++;
    end
    cur_cyc = n;
    check_eq("busy_timeout", 32'(busy), 32'd0);
  endtask

  // what the FSM sees at edge e: the line two edges earlier, forced high around a reset
  function automatic bit s_at(input int e);
    if (e < 2) return 1'b1;
    if (rst_rec[e-1] || rst_rec[e-2]) return 1'b1;
    return line_rec[e-2];
  endfunction

  // frame-level model: times are offsets from the edge the start bit was detected
  task automatic run_model(input int last);
    bit            inframe, waiting;
    int            fs, rel;
    logic [DB-1:0] cur, word;
    inframe = 1'b0;
    waiting = 1'b0;
    fs = 0;
    cur = '0;
    for (int e = 0; e < last; e++) begin
      exp_v[e] = 1'b0;
      exp_f[e] = 1'b0;
      if (rst_rec[e]) begin
        inframe = 1'b0;
        waiting = 1'b0;
        cur = '0;
      end else if (waiting) begin
        if (s_at(e)) waiting = 1'b0;
      end else if (inframe) begin
        rel = e - fs;
        if (rel == H) begin
          if (s_at(e)) inframe = 1'b0;
        end else if (rel == H + (DB + 1) * CPB) begin
          for (int k = 0; k < DB; k++) word[k] = s_at(fs + H + (k + 1) * CPB);
          inframe = 1'b0;
          if (s_at(e)) begin
            cur = word;
            exp_v[e] = 1'b1;
          end else begin
            exp_f[e] = 1'b1;
            waiting = 1'b1;
          end
        end
      end else if (!s_at(e)) begin
        inframe = 1'b1;
        fs = e;
      end
      exp_b[e] = inframe || waiting;
      exp_d[e] = cur;
    end
  endtask

  function automatic int count_valid(input int a, input int b, input logic [DB-1:0] only, input bit any);
    int c;
    c = 0;
    for (int i = a; i < b; i++)
      if (v_rec[i] === 1'b1 && (any || d_rec[i] === only)) c++;
    return c;
  endfunction

  function automatic int count_ferr(input int a, input int b);
    int c;
    c = 0;
    for (int i = a; i < b; i++) if (f_rec[i] === 1'b1) c++;
    return c;
  endfunction

  task automatic check_frame(input string tag, input int fall, input logic [DB-1:0] w);
    cur_cyc = fall + LAT;
    check_eq({tag, "_valid"}, 32'(v_rec[fall + LAT]), 32'd1);
    check_eq({tag, "_data"}, 32'(d_rec[fall + LAT]), 32'(w));
  endtask

  int f1, f2a, f2b, fg, f3, f4a, f4b, f4c, f5, f6, fr, last;
  logic [DB-1:0] w;

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    drive(1'b1, 10);

    send_frame(8'hA5, 1'b1, -1, f1);
    drive(1'b1, 20);

    send_frame(8'h00, 1'b1, -1, f2a);
    send_frame(8'hFF, 1'b1, -1, f2b);
    drive(1'b1, 20);

    fg = n + 1;
    drive(1'b0, 3);
    drive(1'b1, 30);
    send_frame(8'h3C, 1'b1, -1, f3);
    drive(1'b1, 20);

    send_frame(8'h5A, 1'b1, -1, f4a);
    drive(1'b1, 10);
    send_frame(8'h81, 1'b0, -1, f4b);
    drive(1'b0, 40);
    drive(1'b1, 30);
    send_frame(8'h42, 1'b1, -1, f4c);
    drive(1'b1, 20);

    send_frame(8'hC3, 1'b1, 4, f5);
    wait_not_busy(400);
    drive(1'b1, 20);
    send_frame(8'h96, 1'b1, -1, f6);
    drive(1'b1, 20);

    for (int it = 0; it < 40; it++) begin
      w = DB'($urandom);
      case ($urandom_range(0, 9))
        0: begin
          drive(1'b0, $urandom_range(1, H));
          drive(1'b1, 20);
        end
        1: begin
          send_frame(w, 1'b0, -1, fr);
          drive(1'b0, $urandom_range(0, 30));
          drive(1'b1, 20);
        end
        2: send_frame(w, 1'b1, $urandom_range(0, DB - 1), fr);
        default: send_frame(w, 1'b1, -1, fr);
      endcase
      drive(1'b1, $urandom_range(0, 30));
    end
    drive(1'b1, 200);
    last = (n < NMAX) ? n : NMAX;

    // test 1: clean 0xA5, busy from edge 2 until valid
    cur_cyc = f1 + 1;
    check_eq("t1_busy_pre", 32'(b_rec[f1 + 1]), 32'd0);
    cur_cyc = f1 + 2;
    check_eq("t1_busy_start", 32'(b_rec[f1 + 2]), 32'd1);
    cur_cyc = f1 + LAT - 1;
    check_eq("t1_busy_before", 32'(b_rec[f1 + LAT - 1]), 32'd1);
    check_eq("t1_early", 32'(v_rec[f1 + LAT - 1]), 32'd0);
    check_frame("t1", f1, 8'hA5);
    cur_cyc = f1 + LAT;
    check_eq("t1_busy_end", 32'(b_rec[f1 + LAT]), 32'd0);
    check_eq("t1_pulses", 32'(count_valid(f1, f1 + LAT + 20, '0, 1'b1)), 32'd1);

    // test 2: back-to-back 0x00 / 0xFF
    check_frame("t2a", f2a, 8'h00);
    check_frame("t2b", f2b, 8'hFF);
    check_eq("t2_spacing", 32'(f2b - f2a), 32'd160);
    check_eq("t2_ferr", 32'(count_ferr(f2a, f2b + LAT + 10)), 32'd0);

    // test 3: glitch rejected, then 0x3C
    cur_cyc = fg + 2 + H;
    check_eq("t3_busy_drop", 32'(b_rec[fg + 2 + H]), 32'd0);
    check_eq("t3_no_pulse", 32'(count_valid(fg, f3, '0, 1'b1) + count_ferr(fg, f3)), 32'd0);
    check_frame("t3", f3, 8'h3C);

    // test 4: framing error, break held low, then 0x42
    check_frame("t4a", f4a, 8'h5A);
    cur_cyc = f4b + LAT;
    check_eq("t4_ferr", 32'(f_rec[f4b + LAT]), 32'd1);
    check_eq("t4_no_valid", 32'(v_rec[f4b + LAT]), 32'd0);
    check_eq("t4_ferr_count", 32'(count_ferr(f4b, f4c)), 32'd1);
    cur_cyc = f4b + 195;
    check_eq("t4_break_busy", 32'(b_rec[f4b + 195]), 32'd1);
    check_eq("t4_data_held", 32'(d_rec[f4b + 195]), 32'h5A);
    cur_cyc = f4b + 205;
    check_eq("t4_release", 32'(b_rec[f4b + 205]), 32'd0);
    check_frame("t4c", f4c, 8'h42);

    // test 5: reset at data bit 4 of 0xC3, then 0x96
    cur_cyc = f5 + 5 * CPB;
    check_eq("t5_rst_outs", 32'({v_rec[f5 + 5 * CPB], f_rec[f5 + 5 * CPB], b_rec[f5 + 5 * CPB]}), 32'd0);
    check_eq("t5_rst_data", 32'(d_rec[f5 + 5 * CPB]), 32'd0);
    check_eq("t5_no_c3", 32'(count_valid(f5, f6, 8'hC3, 1'b0)), 32'd0);
    check_frame("t5", f6, 8'h96);

    // every recorded cycle against the model
    run_model(last);
    for (int c = 0; c < last; c++) begin
      cur_cyc = c;
      check_eq("cycle", 32'({v_rec[c], f_rec[c], b_rec[c], d_rec[c]}),
               32'({exp_v[c], exp_f[c], exp_b[c], exp_d[c]}));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
